// File: rtl/b4s_loader.sv
// Nibble FIFO feeding a 4-bit parallel-load shift register: pops one nibble,
// strobes load_en for one cycle, then lets the register shift for three cycles.
module b4s_loader #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [3:0]                   in_data,
    output logic                         in_ready,
    output logic [3:0]                   D_out,
    output logic                         load_en,
    output logic                         busy,
    output logic                         frame_done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [1:0]    sc;
    logic [1:0]    sc_nxt;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_nxt;
    logic          load_en_nxt;
    logic          busy_nxt;
    logic          frame_done_nxt;

    // in_ready is registered, so a push never depends on this cycle's pop
    assign push = in_valid & in_ready;

    // Sequencer next state; the pop decision uses only registered occupancy
    always_comb begin
        state_nxt = state;
        sc_nxt    = sc;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    state_nxt = S_LOAD;
                    pop       = 1'b1;
                end
            end
            S_LOAD: begin
                state_nxt = S_SHIFT;
                sc_nxt    = 2'd0;
            end
            S_SHIFT: begin
                if (sc == 2'd2) begin
                    sc_nxt = 2'd0;
                    if (fifo_count != '0) begin
                        state_nxt = S_LOAD;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    sc_nxt = sc + 2'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                sc_nxt    = 2'd0;
            end
        endcase

        load_en_nxt    = (state_nxt == S_LOAD);
        busy_nxt       = (state_nxt != S_IDLE);
        frame_done_nxt = (state_nxt == S_SHIFT) && (sc_nxt == 2'd2);
        count_nxt      = fifo_count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            sc         <= 2'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b0;
            D_out      <= 4'b0000;
            load_en    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            sc         <= sc_nxt;
            fifo_count <= count_nxt;
            in_ready   <= (count_nxt < CW'(DEPTH));
            load_en    <= load_en_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                D_out  <= mem[rd_ptr];
            end
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_b4s_loader.sv
// Directed-vector bench for b4s_loader with a 4-bit shift-register model on
// the load interface to check the resulting serial bit stream.
module tb_b4s_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] D_out;
    logic       load_en;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_count;

    int n_vec = 0;
    int n_bad = 0;

    b4s_loader #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .D_out      (D_out),
        .load_en    (load_en),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shift register: parallel load on en, else shift toward bit 0
    logic [3:0] sr;
    always @(posedge clk) begin
        if (load_en) sr <= D_out;
        else         sr <= {1'b0, sr[3:1]};
    end

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       rdy;
        logic       ld;
        logic [3:0] dout;
        logic       b;
        logic       fd;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [3:0] d, input logic rdy,
                       input logic ld, input logic [3:0] dout, input logic b,
                       input logic fd, input logic [2:0] cnt);
        vec_t x;
        x.v = v; x.d = d; x.rdy = rdy; x.ld = ld; x.dout = dout;
        x.b = b; x.fd = fd; x.cnt = cnt;
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view: {in_ready, load_en, D_out, busy, frame_done, fifo_count}
    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy/ld/dout/busy/fd/cnt=%b_%b_%h_%b_%b_%0d expected %b_%b_%h_%b_%b_%0d",
                     name, act[10], act[9], act[8:5], act[4], act[3], act[2:0],
                     exp[10], exp[9], exp[8:5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    function automatic logic [10:0] outs();
        return {in_ready, load_en, D_out, busy, frame_done, fifo_count};
    endfunction

    logic [7:0] bits_exp;
    logic [7:0] bits_got;

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;

        // Single nibble A
        add(0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
        add(1, 4'hA, 1, 0, 4'h0, 0, 0, 1);
        add(0, 4'h0, 1, 1, 4'hA, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'hA, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'hA, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'hA, 1, 1, 0);
        add(0, 4'h0, 1, 0, 4'hA, 0, 0, 0);
        add(0, 4'h0, 1, 0, 4'hA, 0, 0, 0);
        // Stream 1,2,3 on consecutive edges
        add(1, 4'h1, 1, 0, 4'hA, 0, 0, 1);
        add(1, 4'h2, 1, 1, 4'h1, 1, 0, 1);
        add(1, 4'h3, 1, 0, 4'h1, 1, 0, 2);
        add(0, 4'h0, 1, 0, 4'h1, 1, 0, 2);
        add(0, 4'h0, 1, 0, 4'h1, 1, 1, 2);
        add(0, 4'h0, 1, 1, 4'h2, 1, 0, 1);
        add(0, 4'h0, 1, 0, 4'h2, 1, 0, 1);
        add(0, 4'h0, 1, 0, 4'h2, 1, 0, 1);
        add(0, 4'h0, 1, 0, 4'h2, 1, 1, 1);
        add(0, 4'h0, 1, 1, 4'h3, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'h3, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'h3, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'h3, 1, 1, 0);
        add(0, 4'h0, 1, 0, 4'h3, 0, 0, 0);
        // Fill to full, stall, then drain across pointer wrap
        add(1, 4'h5, 1, 0, 4'h3, 0, 0, 1);
        add(1, 4'h6, 1, 1, 4'h5, 1, 0, 1);
        add(1, 4'h7, 1, 0, 4'h5, 1, 0, 2);
        add(1, 4'h8, 1, 0, 4'h5, 1, 0, 3);
        add(1, 4'h9, 0, 0, 4'h5, 1, 1, 4);
        add(1, 4'hA, 1, 1, 4'h6, 1, 0, 3);
        add(1, 4'hA, 0, 0, 4'h6, 1, 0, 4);
        add(0, 4'h0, 0, 0, 4'h6, 1, 0, 4);
        add(0, 4'h0, 0, 0, 4'h6, 1, 1, 4);
        add(0, 4'h0, 1, 1, 4'h7, 1, 0, 3);
        add(0, 4'h0, 1, 0, 4'h7, 1, 0, 3);
        add(0, 4'h0, 1, 0, 4'h7, 1, 0, 3);
        add(0, 4'h0, 1, 0, 4'h7, 1, 1, 3);
        add(0, 4'h0, 1, 1, 4'h8, 1, 0, 2);
        add(0, 4'h0, 1, 0, 4'h8, 1, 0, 2);
        add(0, 4'h0, 1, 0, 4'h8, 1, 0, 2);
        add(0, 4'h0, 1, 0, 4'h8, 1, 1, 2);
        add(0, 4'h0, 1, 1, 4'h9, 1, 0, 1);
        add(0, 4'h0, 1, 0, 4'h9, 1, 0, 1);
        add(0, 4'h0, 1, 0, 4'h9, 1, 0, 1);
        add(0, 4'h0, 1, 0, 4'h9, 1, 1, 1);
        add(0, 4'h0, 1, 1, 4'hA, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'hA, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'hA, 1, 0, 0);
        add(0, 4'h0, 1, 0, 4'hA, 1, 1, 0);
        add(0, 4'h0, 1, 0, 4'hA, 0, 0, 0);

        // Reset state, held across edges
        #3;
        check("reset_async", outs(), 11'b0);
        step();
        step();
        check("reset_held", outs(), 11'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            step();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].rdy, vecs[i].ld, vecs[i].dout, vecs[i].b, vecs[i].fd, vecs[i].cnt});
        end

        // Reset mid-SHIFT (sc=1) with two nibbles queued
        in_valid = 1'b1; in_data = 4'hB; step();
        in_data = 4'hC; step();
        in_data = 4'hD; step();
        in_valid = 1'b0; step();
        check("pre_reset", outs(), {1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 3'd2});
        rst = 1'b0;
        #2;
        check("reset_mid_frame", outs(), 11'b0);
        in_valid = 1'b1; in_data = 4'hE;
        #2;
        step();
        step();
        check("reset_no_push", outs(), 11'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post_reset%0d", i), outs(), {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0});
        end

        // Serial stream for A then 3 through the shift-register model
        in_valid = 1'b1; in_data = 4'hA; step();
        in_data = 4'h3; step();
        in_valid = 1'b0;
        check("serial_load", outs(), {1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 3'd1});
        bits_exp = 8'b0011_1010;
        bits_got = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            bits_got[i] = sr[0];
        end
        n_vec++;
        if (bits_got !== bits_exp) begin
            n_bad++;
            $display("FAIL serial_bits: got %b expected %b (bit0 first = rightmost)", bits_got, bits_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/b4s_loader.md
B4S_LOADER -- requirements
Module: b4s_loader

Interface
REQ-001 Parameter: DEPTH, 4, nibble FIFO depth; SHALL be a power of two, at least 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-low.
REQ-004 Port: in_valid  input  1  upstream has a nibble on in_data.
REQ-005 Port: in_data  input  4  nibble to serialise; bit 0 leaves the shift register first.
REQ-006 Port: in_ready  output  1  FIFO can accept a nibble this cycle.
REQ-007 Port: D_out  output  4  parallel word; drives the 4-bit shift register's D_in.
REQ-008 Port: load_en  output  1  parallel-load strobe; drives the shift register's en.
REQ-009 Port: busy  output  1  sequencer not in IDLE.
REQ-010 Port: frame_done  output  1  one-cycle pulse during the last shift cycle of a nibble.
REQ-011 Port: fifo_count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-012 Push SHALL occur on an edge where in_valid=1 and in_ready=1; in_ready SHALL be (fifo_count < DEPTH), independent of in_valid.
REQ-013 FIFO SHALL be first-in first-out, with read/write pointers wrapping modulo DEPTH.
REQ-014 There SHALL be no bypass: a nibble pushed into an empty FIFO passes through FIFO storage first.
REQ-015 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-016 When full, only a pop frees space; in_ready SHALL rise in the cycle after the pop edge.
REQ-017 Sequencer states SHALL be IDLE, LOAD and SHIFT, with a 2-bit shift counter sc.
REQ-018 IDLE: if fifo_count>0 at an edge, go to LOAD and pop the head into D_out at that edge; otherwise stay in IDLE.
REQ-019 LOAD: lasts exactly one cycle with load_en=1; next state SHALL be SHIFT with sc=0.
REQ-020 SHIFT: lasts exactly 3 cycles (sc=0,1,2) with load_en=0; frame_done=1 when sc=2.
REQ-021 Leaving SHIFT at sc=2: go to LOAD (popping the head) if fifo_count>0, else go to IDLE.
REQ-022 Back-to-back nibbles SHALL therefore be loaded every 4 cycles with no gap cycles.
REQ-023 load_en, D_out, busy and frame_done SHALL be registered outputs, with no combinational path from inputs.
REQ-024 D_out SHALL hold its value from the pop edge until the next pop edge.
REQ-025 Latency: for a nibble pushed at edge t into an empty FIFO with the sequencer in IDLE, load_en SHALL be high between edges t+1 and t+2, and D_out SHALL equal that nibble from edge t+1.
REQ-026 busy SHALL be 1 in LOAD and SHIFT, 0 in IDLE.
REQ-027 A push arriving while the FIFO is non-empty and the sequencer is mid-SHIFT SHALL NOT perturb the 4-cycle cadence.

Reset
REQ-028 While rst=0, all outputs SHALL be forced immediately (asynchronously): load_en=0, D_out=4'b0000, busy=0, frame_done=0, fifo_count=0, in_ready=0.
REQ-029 On reset, state SHALL be IDLE, sc=0, FIFO pointers 0, and FIFO contents discarded.
REQ-030 After rst deasserts, in_ready SHALL be 1 from the first following clock edge.
REQ-031 A reset asserted mid-frame SHALL abort the frame with no further load_en pulse, and no pushes SHALL be accepted while rst=0.

Verification
REQ-032 Single nibble: push 4'hA at edge t into idle/empty -> load_en=1 only in cycle t+1..t+2, D_out=4'hA, frame_done pulse in cycle t+4..t+5, busy returns to 0 at t+5.
REQ-033 Stream: push 4'h1, 4'h2, 4'h3 on consecutive edges -> load_en pulses exactly 4 cycles apart, D_out sequence 1, 2, 3, three frame_done pulses, fifo_count never exceeds 2.
REQ-034 Full: DEPTH=4, hold in_valid with values 5,6,7,8,9,A -> in_ready drops when fifo_count=4, and order is preserved across pointer wrap.
REQ-035 Simultaneous push and pop at a full FIFO: fifo_count stays at 4 when in_ready was 1 on the prior edge; otherwise no push occurs and fifo_count drops to 3.
REQ-036 Reset mid-SHIFT (sc=1) with 2 nibbles queued -> outputs clear immediately; after release there is no load_en pulse until a new push, and fifo_count=0.
REQ-037 With the bench's shift-register model attached, the serial output bit stream for 4'hA then 4'h3 SHALL be 0,1,0,1,1,1,0,0.
